ifetch: RTL and testbench

Instruction fetch unit: the reading side of the program-counter interface. It takes the 16-bit address and load strobe that the PC presents and fetches the instruction at that address byte by byte over the 8-bit memory read port. It assembles opcode plus 0–2 immediate bytes and hands one complete instruction at a time to the decoder over a valid/ready handshake. It keeps its own fetch pointer, advancing sequentially and reloading from the PC on redirect.

---
 rtl/ifetch_pkg.sv | 28 ++
 rtl/ifetch_ilen_decode.sv | 14 +
 rtl/ifetch.sv | 145 ++++++++++++++
 tb/tb_ifetch.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: definitions shared between the fetch unit and the decoder.
//   - FSM state encoding (3-bit constants)
//   - instruction length constants ILEN_1/2/3
//   - ilen_of(): opcode[7:6] -> instruction length in bytes
package ifetch_pkg;

  localparam logic [2:0] ST_RESET = 3'd0;
  localparam logic [2:0] ST_OP    = 3'd1;
  localparam logic [2:0] ST_IMM1  = 3'd2;
  localparam logic [2:0] ST_IMM2  = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  localparam logic [1:0] ILEN_1 = 2'd1;
  localparam logic [1:0] ILEN_2 = 2'd2;
  localparam logic [1:0] ILEN_3 = 2'd3;

  // Length is encoded only in the two top opcode bits.
  function automatic logic [1:0] ilen_of(input logic [1:0] op_hi);
    logic [1:0] len;
    case (op_hi)
      2'b11:   len = ILEN_3;
      2'b10:   len = ILEN_2;
      default: len = ILEN_1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ifetch_ilen_decode.sv
// ilen_decode: combinational instruction-length decode.
// Instantiated both here and in the decoder so both sides agree on length.
//   op_hi  in  2  opcode bits [7:6]
//   len    out 2  instruction length in bytes (1..3)
module ilen_decode
  import ifetch_pkg::*;
(
  input  logic [1:0] op_hi,
  output logic [1:0] len
);

  assign len = ilen_of(op_hi);

endmodule

// File: rtl/ifetch.sv
// ifetch: instruction fetch unit.
// Fetches opcode plus 0-2 immediate bytes over an 8-bit memory read port,
// then presents one complete instruction to the decoder (valid/ready).
// Keeps its own fetch pointer; pc_ld redirects it to pc_addr.
//   clk, rst_n         clock, asynchronous active-low reset
//   pc_addr, pc_ld     redirect target and strobe
//   mem_addr, mem_req  read request (held until mem_ack)
//   mem_ack, mem_data  beat completion and read data
//   ir_valid, ir_ready instruction handshake
//   ir_op, ir_imm      opcode, immediate (byte1 in [7:0], byte2 in [15:8])
//   ir_len, ir_addr    length in bytes, address of opcode byte
module ifetch
  import ifetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc_addr,
  input  logic        pc_ld,
  output logic [15:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [7:0]  ir_op,
  output logic [15:0] ir_imm,
  output logic [1:0]  ir_len,
  output logic [15:0] ir_addr
);

  logic [2:0]  state, state_d;
  logic [15:0] fptr, fptr_d;
  logic        pend, pend_d;
  logic [15:0] tgt, tgt_d;
  logic        cap_op, cap_imm1, cap_imm2;
  logic        beat;
  logic [1:0]  beat_len;

  assign beat = mem_req & mem_ack;

  ilen_decode u_ilen (
    .op_hi (mem_data[7:6]),
    .len   (beat_len)
  );

  always_comb begin
    state_d  = state;
    fptr_d   = fptr;
    pend_d   = pend;
    tgt_d    = tgt;
    cap_op   = 1'b0;
    cap_imm1 = 1'b0;
    cap_imm2 = 1'b0;
    if (pc_ld && (!mem_req || beat)) begin
      // Nothing outstanding: restart immediately, drop any partial or held
      // instruction (a concurrent HOLD handshake still counts as consumed).
      state_d = ST_OP;
      fptr_d  = pc_addr;
      pend_d  = 1'b0;
    end else if (pc_ld) begin
      // Beat in flight: keep the request up, remember (latest) target.
      pend_d = 1'b1;
      tgt_d  = pc_addr;
    end else if (pend) begin
      // Data of the in-flight beat belongs to the abandoned stream.
      if (beat) begin
        state_d = ST_OP;
        fptr_d  = tgt;
        pend_d  = 1'b0;
      end
    end else begin
      case (state)
        ST_RESET: state_d = ST_OP;
        ST_OP: begin
          if (beat) begin
            cap_op  = 1'b1;
            fptr_d  = fptr + 16'd1;
            state_d = (beat_len == ILEN_1) ? ST_HOLD : ST_IMM1;
          end
        end
        ST_IMM1: begin
          if (beat) begin
            cap_imm1 = 1'b1;
            fptr_d   = fptr + 16'd1;
            state_d  = (ir_len == ILEN_2) ? ST_HOLD : ST_IMM2;
          end
        end
        ST_IMM2: begin
          if (beat) begin
            cap_imm2 = 1'b1;
            fptr_d   = fptr + 16'd1;
            state_d  = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (ir_valid && ir_ready) state_d = ST_OP;
        end
        default: state_d = ST_OP;
      endcase
    end
  end

  // Control and request registers; request outputs are driven from the
  // next state so mem_req/mem_addr are registered yet cycle-accurate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RESET;
      fptr     <= 16'h0000;
      pend     <= 1'b0;
      tgt      <= 16'h0000;
      mem_req  <= 1'b0;
      mem_addr <= 16'h0000;
      ir_valid <= 1'b0;
    end else begin
      state    <= state_d;
      fptr     <= fptr_d;
      pend     <= pend_d;
      tgt      <= tgt_d;
      mem_req  <= (state_d == ST_OP) || (state_d == ST_IMM1) ||
                  (state_d == ST_IMM2);
      mem_addr <= fptr_d;
      ir_valid <= (state_d == ST_HOLD);
    end
  end

  // Instruction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_op   <= 8'h00;
      ir_imm  <= 16'h0000;
      ir_len  <= ILEN_1;
      ir_addr <= 16'h0000;
    end else begin
      if (cap_op) begin
        ir_op   <= mem_data;
        ir_imm  <= 16'h0000;
        ir_len  <= beat_len;
        ir_addr <= fptr;
      end
      if (cap_imm1) ir_imm[7:0]  <= mem_data;
      if (cap_imm2) ir_imm[15:8] <= mem_data;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc_addr;
  logic        pc_ld;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data = 8'h00;
  logic        ir_valid;
  logic        ir_ready;
  logic [7:0]  ir_op;
  logic [15:0] ir_imm;
  logic [1:0]  ir_len;
  logic [15:0] ir_addr;

  int checks = 0;
  int errors = 0;
  int wait_n = 0;
  int wcnt   = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] beat_q [$];
  logic [41:0] inst_q [$];   // {op, imm, len, addr}

  ifetch dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pc_addr  (pc_addr),
    .pc_ld    (pc_ld),
    .mem_addr (mem_addr),
    .mem_req  (mem_req),
    .mem_ack  (mem_ack),
    .mem_data (mem_data),
    .ir_valid (ir_valid),
    .ir_ready (ir_ready),
    .ir_op    (ir_op),
    .ir_imm   (ir_imm),
    .ir_len   (ir_len),
    .ir_addr  (ir_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Memory responder with programmable wait states; also the beat-address
  // monitor. Drives on the falling edge, the DUT samples on the rising edge.
  always @(negedge clk) begin
    if (!mem_req) begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end else begin
      if (mem_ack) wcnt = 0;
      if (wcnt >= wait_n) begin
        mem_ack  = 1'b1;
        mem_data = mem[mem_addr];
        if (beat_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_addr: unexpected beat at 0x%0h", mem_addr);
        end else begin
          chk("beat_addr", {48'h0, mem_addr}, {48'h0, beat_q.pop_front()});
        end
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end
  end

  // Instruction monitor: compare on every handshake.
  always @(negedge clk) begin
    if (rst_n && ir_valid && ir_ready) begin
      if (inst_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL instr: unexpected instruction op=0x%0h addr=0x%0h", ir_op, ir_addr);
      end else begin
        chk("instr{op,imm,len,addr}", {22'h0, ir_op, ir_imm, ir_len, ir_addr},
            {22'h0, inst_q.pop_front()});
      end
    end
  end

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!ir_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_valid"}, {63'h0, ir_valid}, 64'h1);
  endtask

  // Accept the held instruction, then expect the next opcode request at nxt.
  task automatic hs(input string nm, input logic [15:0] nxt);
    wait_valid(nm);
    ir_ready = 1'b1;
    @(posedge clk); #1;
    ir_ready = 1'b0;
    chk({nm, "_next_req"}, {63'h0, mem_req}, 64'h1);
    chk({nm, "_next_addr"}, {48'h0, mem_addr}, {48'h0, nxt});
  endtask

  task automatic wait_req(input string nm, input logic [15:0] a);
    int n = 0;
    while (!(mem_req && mem_addr == a) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_req_seen"}, {48'h0, mem_addr}, {48'h0, a});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_valid;
    int   n;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'h12;
    mem[16'h0001] = 8'h01;
    mem[16'h0010] = 8'hC5;
    mem[16'h0011] = 8'h34;
    mem[16'h0012] = 8'h12;
    mem[16'h0013] = 8'h80;
    mem[16'h0014] = 8'h7F;
    mem[16'h0015] = 8'hC1;
    mem[16'h0016] = 8'h22;
    mem[16'h4000] = 8'h3E;
    mem[16'hFFFF] = 8'hC0;

    rst_n = 1'b0; pc_ld = 1'b0; pc_addr = 16'h0000; ir_ready = 1'b0;
    #12;
    // Reset values
    chk("rst_mem_req",  {63'h0, mem_req},  64'h0);
    chk("rst_mem_addr", {48'h0, mem_addr}, 64'h0);
    chk("rst_ir_valid", {63'h0, ir_valid}, 64'h0);
    chk("rst_ir_op",    {56'h0, ir_op},    64'h0);
    chk("rst_ir_imm",   {48'h0, ir_imm},   64'h0);
    chk("rst_ir_len",   {62'h0, ir_len},   64'h1);
    chk("rst_ir_addr",  {48'h0, ir_addr},  64'h0);

    // Reset release, 1-byte fetch at 0x0000
    beat_q.push_back(16'h0000);
    inst_q.push_back({8'h12, 16'h0000, 2'd1, 16'h0000});
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_req",  {63'h0, mem_req},  64'h1);
    chk("first_addr", {48'h0, mem_addr}, 64'h0);
    beat_q.push_back(16'h0001);
    hs("t1", 16'h0001);
    wait_valid("t1_op01");

    // 3-byte instruction with 2 wait cycles per beat, redirect from HOLD
    wait_n = 2;
    beat_q.push_back(16'h0010);
    beat_q.push_back(16'h0011);
    beat_q.push_back(16'h0012);
    inst_q.push_back({8'hC5, 16'h1234, 2'd3, 16'h0010});
    pc_ld = 1'b1; pc_addr = 16'h0010;
    @(posedge clk); #1;
    pc_ld = 1'b0;
    chk("t2_valid_dropped", {63'h0, ir_valid}, 64'h0);
    chk("t2_first_addr", {48'h0, mem_addr}, 64'h0010);
    for (int i = 0; i < 9; i++) begin
      chk("t2_req_held", {63'h0, mem_req}, 64'h1);
      @(posedge clk); #1;
    end
    chk("t2_valid_latency", {63'h0, ir_valid}, 64'h1);
    wait_n = 0;
    beat_q.push_back(16'h0013);
    beat_q.push_back(16'h0014);
    inst_q.push_back({8'h80, 16'h007F, 2'd2, 16'h0013});
    hs("t2", 16'h0013);

    // Backpressure on a 2-byte instruction
    wait_valid("t3");
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_stable{valid,req,op,imm,len,addr}",
          {20'h0, ir_valid, mem_req, ir_op, ir_imm, ir_len, ir_addr},
          {20'h0, 1'b1, 1'b0, 8'h80, 16'h007F, 2'd2, 16'h0013});
      @(posedge clk); #1;
    end
    wait_n = 3;
    beat_q.push_back(16'h0015);
    beat_q.push_back(16'h0016);
    hs("t3", 16'h0015);

    // Redirect while the IMM1 beat is waiting for ack; second pc_ld overrides
    wait_req("t4", 16'h0016);
    pc_ld = 1'b1; pc_addr = 16'h3000;
    @(posedge clk); #1;
    pc_addr = 16'h4000;
    @(posedge clk); #1;
    pc_ld = 1'b0;
    chk("t4_req_held", {47'h0, mem_req, mem_addr}, {47'h0, 1'b1, 16'h0016});
    beat_q.push_back(16'h4000);
    inst_q.push_back({8'h3E, 16'h0000, 2'd1, 16'h4000});
    saw_valid = 1'b0;
    n = 0;
    while (mem_addr == 16'h0016 && n < 20) begin
      if (ir_valid) saw_valid = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    if (ir_valid) saw_valid = 1'b1;
    chk("t4_redirect_addr", {47'h0, mem_req, mem_addr}, {47'h0, 1'b1, 16'h4000});
    chk("t4_no_valid", {63'h0, saw_valid}, 64'h0);
    wait_n = 0;

    // Wrap: redirect to 0xFFFF from HOLD together with ir_ready
    mem[16'h0000] = 8'hAA;
    mem[16'h0001] = 8'hBB;
    beat_q.push_back(16'hFFFF);
    beat_q.push_back(16'h0000);
    beat_q.push_back(16'h0001);
    inst_q.push_back({8'hC0, 16'hBBAA, 2'd3, 16'hFFFF});
    wait_valid("t5_3e");
    ir_ready = 1'b1; pc_ld = 1'b1; pc_addr = 16'hFFFF;
    @(posedge clk); #1;
    ir_ready = 1'b0; pc_ld = 1'b0;
    chk("t5_redirect", {47'h0, mem_req, mem_addr}, {47'h0, 1'b1, 16'hFFFF});
    mem[16'h0002] = 8'hC7;
    mem[16'h0003] = 8'h11;
    mem[16'h0004] = 8'h22;
    wait_n = 2;
    beat_q.push_back(16'h0002);
    beat_q.push_back(16'h0003);
    hs("t5", 16'h0002);

    // Asynchronous reset during the IMM2 wait
    wait_req("t6", 16'h0004);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t6_req_dropped",   {63'h0, mem_req},  64'h0);
    chk("t6_valid_dropped", {63'h0, ir_valid}, 64'h0);
    wait_n = 0;
    mem[16'h0002] = 8'h05;
    beat_q.push_back(16'h0000);
    beat_q.push_back(16'h0001);
    inst_q.push_back({8'hAA, 16'h00BB, 2'd2, 16'h0000});
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_restart", {47'h0, mem_req, mem_addr}, {47'h0, 1'b1, 16'h0000});
    beat_q.push_back(16'h0002);
    hs("t6", 16'h0002);
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("end_beats_pending", {32'h0, beat_q.size()}, 64'h0);
    chk("end_instr_pending", {32'h0, inst_q.size()}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
